// File: rtl/wb_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// wb_trace_buffer_if
//
// Groups the control, capture and drain signals of wb_trace_buffer.
//   slave  modport : seen by the trace buffer itself
//   master modport : seen by whoever drives the buffer (datapath/debug host)
//
// Signals
//   arm, stop, wrap_mode, trig_pc     control from the debug host
//   in_valid, in_pc, in_data          per-cycle write-back stream from the datapath
//   out_ready                         drain-side accept
//   out_valid, out_pc, out_data       head entry of the FIFO
//   count, state, overflow            status
// ----------------------------------------------------------------------------
interface wb_trace_buffer_if #(
    parameter int AW = 4
);
    logic          arm;
    logic          stop;
    logic          wrap_mode;
    logic [31:0]   trig_pc;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_data;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_data;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic          overflow;

    modport slave (
        input  arm, stop, wrap_mode, trig_pc,
        input  in_valid, in_pc, in_data,
        input  out_ready,
        output out_valid, out_pc, out_data,
        output count, state, overflow
    );

    modport master (
        output arm, stop, wrap_mode, trig_pc,
        output in_valid, in_pc, in_data,
        output out_ready,
        input  out_valid, out_pc, out_data,
        input  count, state, overflow
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// wb_trace_buffer
//
// Triggered capture buffer for the datapath write-back stream. Once armed it
// waits for in_pc == trig_pc, then records {pc, data} pairs into a DEPTH-entry
// circular FIFO, either stopping when full or overwriting the oldest entry.
// A valid/ready port drains the FIFO head.
//
// Ports
//   Clk   single clock, all state on the rising edge
//   Rst   synchronous active-high reset
//   bus   wb_trace_buffer_if.slave (control, capture stream, drain, status)
//
// State encoding: IDLE=00, ARMED=01, CAPTURE=10, DONE=11.
// ----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    wb_trace_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_e;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            wrap_q, wrap_d;
    logic [63:0]     mem_q [DEPTH];

    logic            empty;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            trig_hit;
    logic            arm_ok;
    logic [63:0]     head;

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wrap_d     = wrap_q;
        wr_en      = 1'b0;

        empty    = (count_q == '0);
        full     = (count_q == FULL);
        pop      = !empty && bus.out_ready;
        trig_hit = bus.in_valid && (bus.in_pc == bus.trig_pc);
        arm_ok   = bus.arm && ((state_q == S_IDLE) || (state_q == S_DONE));

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                // stop beats a coincident trigger: no entry is written.
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (trig_hit) begin
                    wr_en   = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // In stop mode a full FIFO is never written without a pop.
                wr_en = bus.in_valid && (wrap_q || !full || pop);
                if (bus.stop) begin
                    state_d = S_DONE;
                end else if (!wrap_q && wr_en && !pop && (count_q == FULL - 1'b1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (arm_ok) begin
            // Accepted arm clears the FIFO; any coincident pop is discarded.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            wrap_d     = bus.wrap_mode;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

            if (wr_en && !pop) begin
                if (full) begin
                    // Overwrite oldest: drop the head to make room.
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wrap_q     <= wrap_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; count gates every read,
    // so stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_pc, bus.in_data};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid = !empty;
    assign bus.out_pc    = empty ? 32'h0 : head[63:32];
    assign bus.out_data  = empty ? 32'h0 : head[31:0];
    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_wb_trace_buffer
//
// Self-checking bench for wb_trace_buffer with DEPTH=4. Every cycle the DUT is
// compared against a queue-based reference model; a stimulus table and a few
// hand-written sequences additionally carry explicit expected values, and a
// randomized phase exercises arbitrary interleavings.
// ----------------------------------------------------------------------------
module tb_wb_trace_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    always #5 Clk = ~Clk;

    wb_trace_buffer_if #(.AW(AW)) bus ();

    wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO as a queue of {pc, data}, state per the encoding.
    logic [63:0] mq[$];
    logic [1:0]  m_state = 2'd0;
    logic        m_ovf   = 1'b0;
    logic        m_wrap  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic pop_ok;
        if (Rst) begin
            mq.delete();
            m_state = 2'd0;
            m_ovf   = 1'b0;
            m_wrap  = 1'b0;
            return;
        end
        pop_ok = (mq.size() != 0) && bus.out_ready;
        case (m_state)
            2'd0, 2'd3: begin
                if (bus.arm) begin
                    mq.delete();
                    m_ovf   = 1'b0;
                    m_wrap  = bus.wrap_mode;
                    m_state = 2'd1;
                end else if (pop_ok) begin
                    void'(mq.pop_front());
                end
            end
            2'd1: begin
                if (pop_ok) void'(mq.pop_front());
                if (bus.stop) m_state = 2'd0;
                else if (bus.in_valid && bus.in_pc == bus.trig_pc) begin
                    mq.push_back({bus.in_pc, bus.in_data});
                    m_state = 2'd2;
                end
            end
            default: begin
                if (pop_ok) void'(mq.pop_front());
                if (bus.in_valid) begin
                    if (mq.size() == DEPTH) begin
                        void'(mq.pop_front());
                        m_ovf = 1'b1;
                    end
                    mq.push_back({bus.in_pc, bus.in_data});
                end
                if (bus.stop) m_state = 2'd3;
                else if (!m_wrap && bus.in_valid && mq.size() == DEPTH) m_state = 2'd3;
            end
        endcase
    endtask

    task automatic compare_model();
        logic [63:0] hd;
        hd = (mq.size() != 0) ? mq[0] : 64'h0;
        check("model_state",    bus.state,     m_state);
        check("model_count",    bus.count,     mq.size());
        check("model_valid",    bus.out_valid, mq.size() != 0);
        check("model_pc",       bus.out_pc,    hd[63:32]);
        check("model_data",     bus.out_data,  hd[31:0]);
        check("model_overflow", bus.overflow,  m_ovf);
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic a, input logic s, input logic w, input logic iv,
                         input logic [31:0] pc, input logic [31:0] d, input logic rdy);
        bus.arm       = a;
        bus.stop      = s;
        bus.wrap_mode = w;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    // Shorthand: one cycle with data = pc + 0x100.
    task automatic cyc(input logic a, input logic s, input logic w, input logic iv,
                       input logic [31:0] pc, input logic rdy);
        drive(a, s, w, iv, pc, pc + 32'h100, rdy);
        step();
    endtask

    task automatic expect_head(input string name, input logic [1:0] st, input int cnt,
                               input logic v, input logic [31:0] pc);
        check({name, "_state"}, bus.state, st);
        check({name, "_count"}, bus.count, cnt);
        check({name, "_valid"}, bus.out_valid, v);
        check({name, "_pc"},    bus.out_pc, v ? pc : 32'h0);
        check({name, "_data"},  bus.out_data, v ? pc + 32'h100 : 32'h0);
    endtask

    typedef struct {
        logic        arm;
        logic        stop;
        logic        wrap;
        logic        iv;
        logic [31:0] pc;
        logic        rdy;
        logic [1:0]  e_state;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[12];

    initial begin
        // Stop-mode capture with trig_pc = 0x10, then drain.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd1, 0, 1'b0, 32'h00};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 2'd1, 0, 1'b0, 32'h00};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b0, 2'd1, 0, 1'b0, 32'h00};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 2'd2, 1, 1'b1, 32'h10};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 2'd2, 2, 1'b1, 32'h10};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h18, 1'b0, 2'd2, 3, 1'b1, 32'h10};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1C, 1'b0, 2'd3, 4, 1'b1, 32'h10};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 2'd3, 4, 1'b1, 32'h10};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 3, 1'b1, 32'h14};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 2, 1'b1, 32'h18};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 1, 1'b1, 32'h1C};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd3, 0, 1'b0, 32'h00};

        bus.trig_pc = 32'h10;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h110, 1'b1);

        // Reset held two cycles with traffic present.
        Rst = 1'b1;
        step();
        step();
        expect_head("reset", 2'd0, 0, 1'b0, 32'h0);
        check("reset_overflow", bus.overflow, 1'b0);
        Rst = 1'b0;

        // Table-driven stop-mode sequence.
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].arm, vt[i].stop, vt[i].wrap, vt[i].iv, vt[i].pc, vt[i].rdy);
            expect_head($sformatf("tbl%0d", i), vt[i].e_state, vt[i].e_count,
                        vt[i].e_valid, vt[i].e_pc);
        end

        // Wrap mode: overwrite oldest, arm ignored during CAPTURE.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0);
        expect_head("arm_in_capture", 2'd2, 2, 1'b1, 32'h10);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h18 + 4 * i, 1'b0);
        expect_head("wrap_full", 2'd2, 4, 1'b1, 32'h18);
        check("wrap_overflow", bus.overflow, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0);
        expect_head("wrap_stop", 2'd3, 4, 1'b1, 32'h18);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1);
            expect_head($sformatf("wrap_drain%0d", i), 2'd3, 3 - i, i < 3, 32'h1C + 4 * i);
        end

        // Full + simultaneous pop/write in wrap mode; head held with out_ready=0.
        bus.trig_pc = 32'h40;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h40 + 4 * i, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0);
            expect_head($sformatf("hold%0d", i), 2'd2, 4, 1'b1, 32'h40);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1'b1);
        expect_head("popwrite_full", 2'd2, 4, 1'b1, 32'h44);
        check("popwrite_overflow", bus.overflow, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1);
            expect_head($sformatf("pw_drain%0d", i), 2'd3, 3 - i, i < 3, 32'h48 + 4 * i);
        end

        // stop together with in_valid in CAPTURE: entry written, DONE.
        bus.trig_pc = 32'h10;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0);
        expect_head("stop_with_write", 2'd3, 2, 1'b1, 32'h10);

        // stop together with trigger in ARMED: back to IDLE, nothing written.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        expect_head("stop_with_trig", 2'd0, 0, 1'b0, 32'h0);

        // Reset mid-capture with three entries held.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h18, 1'b0);
        expect_head("pre_reset", 2'd2, 3, 1'b1, 32'h10);
        Rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1C, 1'b0);
        expect_head("mid_reset", 2'd0, 0, 1'b0, 32'h0);
        Rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) bus.trig_pc = 32'h10 + 4 * $urandom_range(0, 7);
            Rst = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 24) == 0,
                  $urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0,
                  32'h10 + 4 * $urandom_range(0, 7),
                  $urandom,
                  $urandom_range(0, 2) == 0);
            step();
        end
        Rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
